// File: rtl/wind_pkg.sv
// Shared types and constants for the wind direction averaging path: FSM states,
// CORDIC gain and an elaboration-time arctangent helper for the angle table.
package wind_pkg;

    typedef enum logic [2:0] {
        StAccum,
        StPre,
        StCordic,
        StScale,
        StOut
    } wind_state_e;

    // CORDIC gain K = 39797 / 2^16
    localparam int unsigned CordicK      = 39797;
    localparam int unsigned CordicKShift = 16;

    // Fractional bits carried inside the CORDIC so truncation in the shifts stays
    // well below one output LSB on both magnitude and angle.
    localparam int unsigned CordicGuard  = 6;

    localparam real Pi = 3.14159265358979323846;

    // atan(2^-i) in units where a full circle equals 2^bits, rounded to nearest
    function automatic int unsigned wind_atan_scaled(input int unsigned i,
                                                     input int unsigned bits);
        real v;
        v = $atan(1.0 / (2.0 ** i)) / (2.0 * Pi) * (2.0 ** bits);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/winddir_avg_polar_if.sv
// Sample-in / result-out handshake bundle of winddir_avg_polar.
interface winddir_avg_polar_if #(
    parameter int unsigned W       = 16,
    parameter int unsigned ANGLE_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_x;
    logic signed [W-1:0] in_y;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_speed;
    logic [ANGLE_W-1:0]  out_dir;
    logic                out_calm;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_speed, out_dir, out_calm
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_speed, out_dir, out_calm
    );
endinterface

// File: rtl/wind_cordic_vec.sv
// Iterative vectoring CORDIC: one micro-rotation per cycle, drives y toward zero and
// accumulates the rotation angle into z. start_i loads x/y/z, done_o marks the last step.
module wind_cordic_vec
    import wind_pkg::*;
#(
    parameter int unsigned DW    = 24,
    parameter int unsigned ZW    = 22,
    parameter int unsigned ITERS = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic [ZW-1:0]        z_i,
    output logic                 done_o,
    output logic signed [DW-1:0] x_o,
    output logic [ZW-1:0]        z_o
);

    localparam int unsigned IW = $clog2(ITERS + 1);

    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] y_q, y_d;
    logic [ZW-1:0]        z_q, z_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 busy_q, busy_d;

    logic [ZW-1:0] atan_tbl [ITERS];

    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        localparam logic [ZW-1:0] Atan = ZW'(wind_atan_scaled(g, ZW));
        assign atan_tbl[g] = Atan;
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_o = 1'b0;
        if (start_i) begin
            x_d    = x_i;
            y_d    = y_i;
            z_d    = z_i;
            iter_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // y >= 0: rotate clockwise, angle accumulates positively
            if (!y_q[DW-1]) begin
                x_d = x_q + (y_q >>> iter_q);
                y_d = y_q - (x_q >>> iter_q);
                z_d = z_q + atan_tbl[iter_q];
            end else begin
                x_d = x_q - (y_q >>> iter_q);
                y_d = y_q + (x_q >>> iter_q);
                z_d = z_q - atan_tbl[iter_q];
            end
            if (iter_q == IW'(ITERS - 1)) begin
                busy_d = 1'b0;
                done_o = 1'b1;
            end else begin
                iter_d = iter_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
        end
    end

    assign x_o = x_q;
    assign z_o = z_q;

endmodule

// File: rtl/winddir_avg_polar.sv
// Vector-averages X/Y wind samples over 2^AVG_LOG2 samples and converts the mean to
// speed/direction via CORDIC. Optional calm hold is enabled by WINDDIR_CALM_EN.
module winddir_avg_polar
    import wind_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned AVG_LOG2    = 3,
    parameter int unsigned ITERS       = 14,
    parameter int unsigned ANGLE_W     = 16,
    parameter int unsigned CALM_THRESH = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    winddir_avg_polar_if.slave  bus_io
);

    localparam int unsigned AW = W + AVG_LOG2;
    localparam int unsigned DW = W + 2 + CordicGuard;
    localparam int unsigned ZW = ANGLE_W + CordicGuard;
    localparam int unsigned CW = AVG_LOG2 + 1;
    localparam int unsigned PW = DW + CordicKShift;
    localparam int unsigned RS = CordicKShift + CordicGuard;
    localparam logic [CW-1:0] LastCnt = CW'((1 << AVG_LOG2) - 1);

`ifdef WINDDIR_CALM_EN
    localparam bit CalmEn = 1'b1;
`else
    localparam bit CalmEn = 1'b0;
`endif

    wind_state_e state_q, state_d;

    logic signed [AW-1:0] acc_x_q, acc_x_d;
    logic signed [AW-1:0] acc_y_q, acc_y_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 zero_q, zero_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_speed_q, out_speed_d;
    logic [ANGLE_W-1:0]   out_dir_q, out_dir_d;
    logic                 out_calm_q, out_calm_d;
`ifdef WINDDIR_CALM_EN
    logic [ANGLE_W-1:0]   held_q, held_d;
`endif

    logic                 accept;
    logic signed [W-1:0]  mean_x, mean_y;
    logic signed [W+1:0]  ext_x, ext_y, pre_x, pre_y;
    logic signed [DW-1:0] cor_x_in, cor_y_in, cor_x;
    logic [ZW-1:0]        cor_z_in, cor_z;
    logic                 cor_start, cor_done;
    logic [DW-1:0]        x_mag;
    logic [PW-1:0]        mag_full;
    logic [W-1:0]         speed_calc;
    logic [ANGLE_W-1:0]   dir_calc;
    logic                 calm_hit;

    assign accept = bus_io.in_valid & in_ready_q;

    // Mean with floor rounding, then fold the left half-plane onto the right.
    assign mean_x   = W'(acc_x_q >>> AVG_LOG2);
    assign mean_y   = W'(acc_y_q >>> AVG_LOG2);
    assign ext_x    = (W + 2)'(mean_x);
    assign ext_y    = (W + 2)'(mean_y);
    assign pre_x    = mean_x[W-1] ? -ext_x : ext_x;
    assign pre_y    = mean_x[W-1] ? -ext_y : ext_y;
    assign cor_x_in = {pre_x, {CordicGuard{1'b0}}};
    assign cor_y_in = {pre_y, {CordicGuard{1'b0}}};
    assign cor_z_in = mean_x[W-1] ? (ZW'(1) << (ZW - 1)) : '0;

    wind_cordic_vec #(
        .DW    (DW),
        .ZW    (ZW),
        .ITERS (ITERS)
    ) u_cordic (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (cor_start),
        .x_i     (cor_x_in),
        .y_i     (cor_y_in),
        .z_i     (cor_z_in),
        .done_o  (cor_done),
        .x_o     (cor_x),
        .z_o     (cor_z)
    );

    // Magnitude = round(x * K), guard bits dropped in the same rounding step.
    assign x_mag      = cor_x[DW-1] ? '0 : cor_x;
    assign mag_full   = ((PW'(x_mag) * PW'(CordicK)) + (PW'(1) << (RS - 1))) >> RS;
    assign speed_calc = (|mag_full[PW-1:W]) ? '1 : mag_full[W-1:0];
    assign dir_calc   = ANGLE_W'((cor_z + ZW'(1 << (CordicGuard - 1))) >> CordicGuard);
    assign calm_hit   = CalmEn && (32'(speed_calc) < CALM_THRESH);

    always_comb begin
        state_d     = state_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        out_speed_d = out_speed_q;
        out_dir_d   = out_dir_q;
        out_calm_d  = out_calm_q;
        cor_start   = 1'b0;
`ifdef WINDDIR_CALM_EN
        held_d      = held_q;
`endif
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_x_d = acc_x_q + AW'(bus_io.in_x);
                    acc_y_d = acc_y_q + AW'(bus_io.in_y);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StPre;
                    end
                end
            end
            StPre: begin
                cor_start = 1'b1;
                zero_d    = (mean_x == '0) && (mean_y == '0);
                state_d   = StCordic;
            end
            StCordic: begin
                if (cor_done) begin
                    state_d = StScale;
                end
            end
            StScale: begin
                out_valid_d = 1'b1;
                out_speed_d = speed_calc;
                out_calm_d  = calm_hit;
`ifdef WINDDIR_CALM_EN
                if (calm_hit) begin
                    out_dir_d = held_q;
                end else begin
                    out_dir_d = zero_q ? '0 : dir_calc;
                    held_d    = out_dir_d;
                end
`else
                out_dir_d = zero_q ? '0 : dir_calc;
`endif
                state_d = StOut;
            end
            StOut: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_x_d     = '0;
                    acc_y_d     = '0;
                    cnt_d       = '0;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
        in_ready_d = (state_d == StAccum);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StAccum;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_speed_q <= '0;
            out_dir_q   <= '0;
            out_calm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_speed_q <= out_speed_d;
            out_dir_q   <= out_dir_d;
            out_calm_q  <= out_calm_d;
        end
    end

`ifdef WINDDIR_CALM_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end
`endif

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_speed = out_speed_q;
    assign bus_io.out_dir   = out_dir_q;
    assign bus_io.out_calm  = out_calm_q;

endmodule

// File: tb/tb_winddir_avg_polar.sv
// Self-checking bench for winddir_avg_polar: table of averaging windows with a
// scoreboard queue, plus stall and mid-CORDIC reset sequences.
module tb_winddir_avg_polar;

    localparam int W        = 16;
    localparam int AVG_LOG2 = 3;
    localparam int ITERS    = 14;
    localparam int ANGLE_W  = 16;
    localparam int NS       = 1 << AVG_LOG2;

`ifdef WINDDIR_CALM_EN
    localparam bit CALM = 1'b1;
`else
    localparam bit CALM = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    winddir_avg_polar_if #(.W(W), .ANGLE_W(ANGLE_W)) bus ();

    winddir_avg_polar #(
        .W           (W),
        .AVG_LOG2    (AVG_LOG2),
        .ITERS       (ITERS),
        .ANGLE_W     (ANGLE_W),
        .CALM_THRESH (64)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    typedef struct {
        int id;
        int speed;
        int tol_s;
        int dir;
        int tol_d;
        bit calm;
    } exp_t;

    typedef struct {
        int xa;
        int ya;
        int xb;
        int yb;
        int speed;
        int tol_s;
        int dir;
        int tol_d;
        bit calm;
    } vec_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic chk_ang(input string name, input int act, input int exp, input int tol);
        int d;
        d = (act - exp) & 32'hFFFF;
        if (d >= 32768) d = d - 65536;
        total++;
        if (d < -tol || d > tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d +/- %0d (circular)", name, act, exp, tol);
        end
    endtask

    task automatic send(input int x, input int y);
        int budget;
        bit acc;
        budget       = 200;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = W'(x);
        bus.in_y     = W'(y);
        while (!acc && budget > 0) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send: in_ready got 0, want 1 within 200 cycles");
        end
    endtask

    task automatic collect();
        int lat;
        exp_t e;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid: got 0, want 1 within 100 cycles");
            return;
        end
        chk("latency", lat, ITERS + 2, 0);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got result, want none pending");
            return;
        end
        e = sb.pop_front();
        chk($sformatf("w%0d speed", e.id), int'(bus.out_speed), e.speed, e.tol_s);
        chk_ang($sformatf("w%0d dir", e.id), int'(bus.out_dir), e.dir, e.tol_d);
        chk($sformatf("w%0d calm", e.id), int'(bus.out_calm), int'(e.calm), 0);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid after ack", int'(bus.out_valid), 0, 0);
        chk("in_ready after ack", int'(bus.in_ready), 1, 0);
    endtask

    task automatic drive_window(input int xa, input int ya, input int xb, input int yb);
        for (int i = 0; i < NS; i++) begin
            if (i < NS / 2) send(xa, ya);
            else            send(xb, yb);
        end
    endtask

    vec_t tbl[9];

    initial begin
        exp_t e;
        int changed;
        int ir_bad;
        int ov_bad;
        logic [W-1:0]       s0;
        logic [ANGLE_W-1:0] d0;

        tbl[0] = '{1024, 0, 1024, 0, 1024, 1, 0, 2, 1'b0};
        tbl[1] = '{0, 1024, 0, 1024, 1024, 1, 16384, 2, 1'b0};
        tbl[2] = '{-1024, -1024, -1024, -1024, 1448, 2, 40960, 2, 1'b0};
        tbl[3] = '{512, 512, 512, 512, 724, 2, 8192, 2, 1'b0};
        tbl[4] = '{1024, 0, -1024, 0, 0, 0, CALM ? 8192 : 0, 2, CALM};
        tbl[5] = '{-32768, 0, -32768, 0, 32768, 2, 32768, 2, 1'b0};
        tbl[6] = '{-32768, -32768, -32768, -32768, 46341, 2, 40960, 2, 1'b0};
        tbl[7] = '{1000, -300, 1000, -300, 1044, 2, 62496, 2, 1'b0};
        tbl[8] = '{10, 20, 10, 20, 22, 1, CALM ? 62496 : 11548, CALM ? 2 : 100, CALM};

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;

        #2;
        chk("reset in_ready", int'(bus.in_ready), 0, 0);
        chk("reset out_valid", int'(bus.out_valid), 0, 0);
        chk("reset out_speed", int'(bus.out_speed), 0, 0);
        chk("reset out_dir", int'(bus.out_dir), 0, 0);
        chk("reset out_calm", int'(bus.out_calm), 0, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after release", int'(bus.in_ready), 1, 0);

        for (int i = 0; i < 9; i++) begin
            e = '{i, tbl[i].speed, tbl[i].tol_s, tbl[i].dir, tbl[i].tol_d, tbl[i].calm};
            sb.push_back(e);
            drive_window(tbl[i].xa, tbl[i].ya, tbl[i].xb, tbl[i].yb);
            collect();
            ack();
        end

        // Stall: out_ready low for 20 cycles while junk samples are offered.
        sb.push_back('{20, 1024, 1, 0, 2, 1'b0});
        drive_window(1024, 0, 1024, 0);
        collect();
        s0           = bus.out_speed;
        d0           = bus.out_dir;
        changed      = 0;
        ir_bad       = 0;
        ov_bad       = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = 16'sd20000;
        bus.in_y     = 16'sd20000;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_speed !== s0 || bus.out_dir !== d0) changed++;
            if (bus.in_ready !== 1'b0) ir_bad++;
            if (bus.out_valid !== 1'b1) ov_bad++;
        end
        bus.in_valid = 1'b0;
        chk("stall outputs changed", changed, 0, 0);
        chk("stall in_ready high cycles", ir_bad, 0, 0);
        chk("stall out_valid low cycles", ov_bad, 0, 0);
        ack();
        sb.push_back('{21, 1024, 1, 16384, 2, 1'b0});
        drive_window(0, 1024, 0, 1024);
        collect();
        ack();

        // Reset in the middle of CORDIC; the partial window produces no result.
        drive_window(512, 512, 512, 512);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort out_speed", int'(bus.out_speed), 0, 0);
        chk("abort out_dir", int'(bus.out_dir), 0, 0);
        chk("abort out_valid", int'(bus.out_valid), 0, 0);
        chk("abort in_ready", int'(bus.in_ready), 0, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{22, 724, 2, 8192, 2, 1'b0});
        drive_window(512, 512, 512, 512);
        collect();
        ack();

        chk("scoreboard drained", sb.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
